// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the core's fetch/data ports, the arbiter and the shared memory.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  // Instruction-fetch port
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ready;
  logic [DATA_W-1:0] if_rdata;
  // Data (load/store) port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ready;
  logic [DATA_W-1:0] d_rdata;
  // Memory side
  logic              mem_valid;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter view
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ready, if_rdata, d_ready, d_rdata, mem_valid, mem_we, mem_addr, mem_wdata
  );

  // Core pipeline plus memory model view
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ready, if_rdata, d_ready, d_rdata, mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and data accesses onto one fixed-latency memory port.
// Contention alternates between ports; completion is a one-cycle ready pulse.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LATENCY = 4
) (
  input logic               clk,
  input logic               reset_n,
  mem_port_arbiter_if.slave bus
);

  localparam int unsigned CntW = $clog2(MEM_LATENCY + 1);

  typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

  state_e            state_q;
  logic [CntW-1:0]   cnt_q;
  logic              last_d_q;  // 1: data port won the most recent grant
  logic              mem_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              if_ready_q;
  logic              d_ready_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic i_elig;
  logic d_elig;
  logic grant_i;
  logic grant_d;

  // Eligibility and arbitration; a port in its ready cycle is still holding its
  // old request, so it must not be granted again.
  always_comb begin
    i_elig  = bus.if_req & ~if_ready_q;
    d_elig  = bus.d_req & ~d_ready_q;
    grant_d = d_elig & (~i_elig | ~last_d_q);
    grant_i = i_elig & ~grant_d;
  end

  // Grant FSM, latency counter and all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      last_d_q    <= 1'b0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      mem_valid_q <= 1'b0;
      if_ready_q  <= 1'b0;
      d_ready_q   <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_d) begin
            state_q     <= StBusyD;
            mem_valid_q <= 1'b1;
            mem_we_q    <= bus.d_we;
            mem_addr_q  <= bus.d_addr;
            mem_wdata_q <= bus.d_wdata;
            cnt_q       <= CntW'(MEM_LATENCY);
            last_d_q    <= 1'b1;
          end else if (grant_i) begin
            state_q     <= StBusyI;
            mem_valid_q <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= bus.if_addr;
            mem_wdata_q <= '0;
            cnt_q       <= CntW'(MEM_LATENCY);
            last_d_q    <= 1'b0;
          end
        end
        StBusyI, StBusyD: begin
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q <= StIdle;
            if (state_q == StBusyI) begin
              if_rdata_q <= bus.mem_rdata;
              if_ready_q <= 1'b1;
            end else begin
              // Stores leave the last load result untouched
              if (!mem_we_q) begin
                d_rdata_q <= bus.mem_rdata;
              end
              d_ready_q <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.mem_valid = mem_valid_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.if_ready  = if_ready_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a latency-4 instance driven by directed and random
// transaction lists scheduled by a transaction-level model, plus a latency-1 instance.
module tb_mem_port_arbiter;

  localparam int LAT = 4;
  localparam int NC  = 200;

  logic clk;
  logic reset_n;
  int   checks;
  int   errors;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(LAT)) u_dut0 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus0)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) u_dut1 (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory contents as a pure function of address
  function automatic logic [31:0] memword(input logic [31:0] a);
    if (a == 32'h100) return 32'hDEADBEEF;
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  // Latency-4 memory: read data valid only LAT-1 cycles after the issue cycle
  int unsigned cyc;
  bit          h_valid [LAT-1];
  bit          h_we    [LAT-1];
  bit [31:0]   h_addr  [LAT-1];
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    h_valid[0] <= bus0.mem_valid;
    h_we[0]    <= bus0.mem_we;
    h_addr[0]  <= bus0.mem_addr;
    for (int i = 1; i < LAT - 1; i++) begin
      h_valid[i] <= h_valid[i-1];
      h_we[i]    <= h_we[i-1];
      h_addr[i]  <= h_addr[i-1];
    end
  end
  assign bus0.mem_rdata = (h_valid[LAT-2] && !h_we[LAT-2]) ? memword(h_addr[LAT-2])
                                                           : (32'hBAD00000 ^ cyc);
  // Latency-1 memory: data valid in the issue cycle itself
  assign bus1.mem_rdata = (bus1.mem_valid && !bus1.mem_we) ? memword(bus1.mem_addr)
                                                           : (32'hBAD10000 ^ cyc);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Transaction lists per port
  logic [31:0] ti_addr[$];
  int          ti_gap[$];
  bit          td_we[$];
  logic [31:0] td_addr[$];
  logic [31:0] td_wdata[$];
  int          td_gap[$];

  task automatic clear_q();
    ti_addr.delete(); ti_gap.delete();
    td_we.delete(); td_addr.delete(); td_wdata.delete(); td_gap.delete();
  endtask

  task automatic add_i(input logic [31:0] addr, input int gap);
    ti_addr.push_back(addr); ti_gap.push_back(gap);
  endtask

  task automatic add_d(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                       input int gap);
    td_we.push_back(we); td_addr.push_back(addr); td_wdata.push_back(wdata);
    td_gap.push_back(gap);
  endtask

  function automatic int gap_rand();
    if ($urandom_range(0, 2) == 0) return int'($urandom_range(1, 3));
    return 0;
  endfunction

  task automatic make_random(input int n);
    clear_q();
    for (int k = 0; k < n; k++) begin
      if ($urandom_range(0, 3) != 0) add_i($urandom & 32'hFFFC, gap_rand());
      if ($urandom_range(0, 3) != 0) begin
        add_d(1'($urandom_range(0, 1)), $urandom & 32'hFFFC, $urandom, gap_rand());
      end
    end
  endtask

  // Model state carried across phases
  bit          m_last_d;
  logic [31:0] cur_i;
  logic [31:0] cur_d;

  // Per-cycle plan (stimulus) and expectations
  bit          p_ireq [NC];
  bit          p_dreq [NC];
  bit          p_dwe  [NC];
  logic [31:0] p_iaddr [NC];
  logic [31:0] p_daddr [NC];
  logic [31:0] p_dwdata [NC];
  bit          e_valid [NC];
  bit          e_we [NC];
  bit          e_iready [NC];
  bit          e_dready [NC];
  bit          ev_i [NC];
  bit          ev_d [NC];
  logic [31:0] e_addr [NC];
  logic [31:0] e_wdata [NC];
  logic [31:0] ev_iv [NC];
  logic [31:0] ev_dv [NC];

  // Schedule the queued transactions from the arbitration rules, then drive and check.
  task automatic run_phase(input string name);
    int ni, nd, ki, kd, arr_i, arr_d, rdy_i, rdy_d, t, s, r;
    bit ei, ed, gd;
    for (int c = 0; c < NC; c++) begin
      p_ireq[c] = 0; p_dreq[c] = 0; p_dwe[c] = 1'($urandom_range(0, 1));
      p_iaddr[c] = $urandom; p_daddr[c] = $urandom; p_dwdata[c] = $urandom;
      e_valid[c] = 0; e_we[c] = 0; e_iready[c] = 0; e_dready[c] = 0;
      ev_i[c] = 0; ev_d[c] = 0; e_addr[c] = 0; e_wdata[c] = 0; ev_iv[c] = 0; ev_dv[c] = 0;
    end
    ni = ti_addr.size(); nd = td_addr.size(); ki = 0; kd = 0;
    arr_i = NC; arr_d = NC;
    if (ni > 0) arr_i = ti_gap[0];
    if (nd > 0) arr_d = td_gap[0];
    rdy_i = -1; rdy_d = -1; t = 0;
    while (t + LAT + 2 < NC) begin
      ei = (ki < ni) && (arr_i <= t) && (rdy_i != t);
      ed = (kd < nd) && (arr_d <= t) && (rdy_d != t);
      if (!ei && !ed) begin
        t++;
      end else begin
        gd = ed && (!ei || !m_last_d);
        s = t + 1;
        r = t + LAT + 1;
        e_valid[s] = 1;
        if (gd) begin
          for (int c = arr_d; c <= r; c++) begin
            p_dreq[c] = 1; p_dwe[c] = td_we[kd];
            p_daddr[c] = td_addr[kd]; p_dwdata[c] = td_wdata[kd];
          end
          e_we[s] = td_we[kd]; e_addr[s] = td_addr[kd]; e_wdata[s] = td_wdata[kd];
          e_dready[r] = 1;
          if (!td_we[kd]) begin ev_d[r] = 1; ev_dv[r] = memword(td_addr[kd]); end
          m_last_d = 1; rdy_d = r; kd++;
          if (kd < nd) arr_d = r + 1 + td_gap[kd];
        end else begin
          for (int c = arr_i; c <= r; c++) begin
            p_ireq[c] = 1; p_iaddr[c] = ti_addr[ki];
          end
          e_we[s] = 0; e_addr[s] = ti_addr[ki]; e_wdata[s] = 0;
          e_iready[r] = 1; ev_i[r] = 1; ev_iv[r] = memword(ti_addr[ki]);
          m_last_d = 0; rdy_i = r; ki++;
          if (ki < ni) arr_i = r + 1 + ti_gap[ki];
        end
        t = r;
      end
    end
    for (int c = 0; c < NC; c++) begin
      bus0.if_req = p_ireq[c]; bus0.if_addr = p_iaddr[c];
      bus0.d_req = p_dreq[c]; bus0.d_we = p_dwe[c];
      bus0.d_addr = p_daddr[c]; bus0.d_wdata = p_dwdata[c];
      if (ev_i[c]) cur_i = ev_iv[c];
      if (ev_d[c]) cur_d = ev_dv[c];
      @(negedge clk);
      check1($sformatf("%s mem_valid c%0d", name, c), bus0.mem_valid, e_valid[c]);
      if (e_valid[c]) begin
        check1($sformatf("%s mem_we c%0d", name, c), bus0.mem_we, e_we[c]);
        check($sformatf("%s mem_addr c%0d", name, c), bus0.mem_addr, e_addr[c]);
        check($sformatf("%s mem_wdata c%0d", name, c), bus0.mem_wdata, e_wdata[c]);
      end
      check1($sformatf("%s if_ready c%0d", name, c), bus0.if_ready, e_iready[c]);
      check1($sformatf("%s d_ready c%0d", name, c), bus0.d_ready, e_dready[c]);
      check($sformatf("%s if_rdata c%0d", name, c), bus0.if_rdata, cur_i);
      check($sformatf("%s d_rdata c%0d", name, c), bus0.d_rdata, cur_d);
      @(posedge clk); #1;
    end
  endtask

  task automatic drive_idle();
    bus0.if_req = 0; bus0.if_addr = 0; bus0.d_req = 0; bus0.d_we = 0;
    bus0.d_addr = 0; bus0.d_wdata = 0;
    bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
    bus1.d_addr = 0; bus1.d_wdata = 0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    drive_idle();
    repeat (3) @(posedge clk);
    #1;
    // Reset values of both instances
    check1("rst0 mem_valid", bus0.mem_valid, 1'b0);
    check1("rst0 mem_we", bus0.mem_we, 1'b0);
    check("rst0 mem_addr", bus0.mem_addr, 32'h0);
    check("rst0 mem_wdata", bus0.mem_wdata, 32'h0);
    check1("rst0 if_ready", bus0.if_ready, 1'b0);
    check1("rst0 d_ready", bus0.d_ready, 1'b0);
    check("rst0 if_rdata", bus0.if_rdata, 32'h0);
    check("rst0 d_rdata", bus0.d_rdata, 32'h0);
    check1("rst1 mem_valid", bus1.mem_valid, 1'b0);
    check1("rst1 if_ready", bus1.if_ready, 1'b0);
    check1("rst1 d_ready", bus1.d_ready, 1'b0);
    check("rst1 mem_addr", bus1.mem_addr, 32'h0);
    reset_n = 1'b1;
    m_last_d = 0; cur_i = 0; cur_d = 0;

    // First contention after reset goes to the data port
    clear_q(); add_i(32'h100, 0); add_d(0, 32'h200, 32'h0, 0);
    run_phase("contend");
    // Store leaves d_rdata alone
    clear_q(); add_d(1, 32'h40, 32'h12345678, 0);
    run_phase("store");
    // Lone fetch
    clear_q(); add_i(32'h100, 0);
    run_phase("fetch");
    // Continuous contention: D, I, D, I, ...
    clear_q();
    for (int k = 0; k < 4; k++) begin
      add_i(32'h1000 + 32'(k * 4), 0);
      add_d(1'(k % 2), 32'h2000 + 32'(k * 4), 32'hA5A50000 + 32'(k), 0);
    end
    run_phase("sustain");
    for (int p = 0; p < 3; p++) begin
      make_random(10);
      run_phase($sformatf("rand%0d", p));
    end

    // Reset in the middle of a fetch, request held across reset
    for (int c = 0; c < 13; c++) begin
      bus0.if_req = (c <= 11); bus0.if_addr = 32'h300; bus0.d_req = 0;
      reset_n = !(c >= 3 && c <= 5);
      @(negedge clk);
      check1($sformatf("midrst mem_valid c%0d", c), bus0.mem_valid, (c == 1 || c == 7));
      check1($sformatf("midrst if_ready c%0d", c), bus0.if_ready, (c == 11));
      check1($sformatf("midrst d_ready c%0d", c), bus0.d_ready, 1'b0);
      if (c >= 3 && c <= 5) begin
        check($sformatf("midrst mem_addr c%0d", c), bus0.mem_addr, 32'h0);
        check1($sformatf("midrst mem_we c%0d", c), bus0.mem_we, 1'b0);
        check($sformatf("midrst mem_wdata c%0d", c), bus0.mem_wdata, 32'h0);
        check($sformatf("midrst if_rdata c%0d", c), bus0.if_rdata, 32'h0);
        check($sformatf("midrst d_rdata c%0d", c), bus0.d_rdata, 32'h0);
      end
      if (c == 7) check("midrst mem_addr c7", bus0.mem_addr, 32'h300);
      if (c >= 11) check($sformatf("midrst if_rdata c%0d", c), bus0.if_rdata, memword(32'h300));
      @(posedge clk); #1;
    end
    m_last_d = 0; cur_i = memword(32'h300); cur_d = 0;
    make_random(10);
    run_phase("rand_post_rst");

    // Latency-1 instance: lone load, then contention with last grant = D
    for (int c = 0; c < 10; c++) begin
      bus1.d_req = (c <= 2) || (c >= 4 && c <= 8);
      bus1.d_we = 0;
      bus1.d_addr = (c <= 2) ? 32'h80 : 32'hA0;
      bus1.if_req = (c >= 4 && c <= 6);
      bus1.if_addr = 32'h90;
      @(negedge clk);
      check1($sformatf("lat1 mem_valid c%0d", c), bus1.mem_valid, (c == 1 || c == 5 || c == 7));
      if (c == 1) check("lat1 mem_addr c1", bus1.mem_addr, 32'h80);
      if (c == 5) check("lat1 mem_addr c5", bus1.mem_addr, 32'h90);
      if (c == 7) check("lat1 mem_addr c7", bus1.mem_addr, 32'hA0);
      check1($sformatf("lat1 d_ready c%0d", c), bus1.d_ready, (c == 2 || c == 8));
      check1($sformatf("lat1 if_ready c%0d", c), bus1.if_ready, (c == 6));
      check($sformatf("lat1 d_rdata c%0d", c), bus1.d_rdata,
            (c < 2) ? 32'h0 : ((c < 8) ? memword(32'h80) : memword(32'hA0)));
      check($sformatf("lat1 if_rdata c%0d", c), bus1.if_rdata,
            (c < 6) ? 32'h0 : memword(32'h90));
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
